// File: rtl/wb_arbiter_if.sv
// Writeback bus bundle: three result sources in, one register-file write channel out.
// The master side drives results and flush; the slave side is the arbiter.
interface wb_arbiter_if #(
   parameter int TAG_WIDTH = 2
);
   logic                 flush;

   logic                 alu_valid;
   logic                 alu_ready;
   logic [4:0]           alu_addr;
   logic [TAG_WIDTH-1:0] alu_tag;
   logic [31:0]          alu_data;

   logic                 lsu_valid;
   logic                 lsu_ready;
   logic [4:0]           lsu_addr;
   logic [TAG_WIDTH-1:0] lsu_tag;
   logic [31:0]          lsu_data;

   logic                 mul_valid;
   logic                 mul_ready;
   logic [4:0]           mul_addr;
   logic [TAG_WIDTH-1:0] mul_tag;
   logic [31:0]          mul_data;

   logic                 wr_ch0_en;
   logic [4:0]           wr_ch0_addr;
   logic [TAG_WIDTH-1:0] wr_ch0_tag;
   logic [31:0]          wr_ch0_data;
   logic                 wb_busy;

   modport master (
      output flush,
      output alu_valid, alu_addr, alu_tag, alu_data,
      output lsu_valid, lsu_addr, lsu_tag, lsu_data,
      output mul_valid, mul_addr, mul_tag, mul_data,
      input  alu_ready, lsu_ready, mul_ready,
      input  wr_ch0_en, wr_ch0_addr, wr_ch0_tag, wr_ch0_data, wb_busy
   );

   modport slave (
      input  flush,
      input  alu_valid, alu_addr, alu_tag, alu_data,
      input  lsu_valid, lsu_addr, lsu_tag, lsu_data,
      input  mul_valid, mul_addr, mul_tag, mul_data,
      output alu_ready, lsu_ready, mul_ready,
      output wr_ch0_en, wr_ch0_addr, wr_ch0_tag, wr_ch0_data, wb_busy
   );
endinterface

// File: rtl/wb_arbiter.sv
// Writeback arbiter: per-source FIFOs (ALU=0, LSU=1, MUL=2) round-robined onto one registered write.
// Define WB_BYPASS_EN to let an empty source's incoming result compete in the same cycle.
module wb_arbiter #(
   parameter int TAG_WIDTH  = 2,
   parameter int FIFO_DEPTH = 2
) (
   input logic         clk,
   input logic         reset,
   wb_arbiter_if.slave bus
);
   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int EW = 5 + TAG_WIDTH + 32;
   localparam logic [PW:0] FULL_COUNT = (PW + 1)'(FIFO_DEPTH);

   logic          src_valid [3];
   logic [EW-1:0] src_ent   [3];
   logic [EW-1:0] cand_ent  [3];
   logic [2:0]    src_ready;
   logic [2:0]    not_empty;
   logic [2:0]    xfer;
   logic [2:0]    cand;

   logic          grant_valid;
   logic [1:0]    grant_idx;
   logic [EW-1:0] grant_ent;

   logic [1:0]           rr_ptr_reg;
   logic                 en_reg;
   logic [4:0]           addr_reg;
   logic [TAG_WIDTH-1:0] tag_reg;
   logic [31:0]          data_reg;

   assign src_valid[0] = bus.alu_valid;
   assign src_valid[1] = bus.lsu_valid;
   assign src_valid[2] = bus.mul_valid;
   assign src_ent[0]   = {bus.alu_addr, bus.alu_tag, bus.alu_data};
   assign src_ent[1]   = {bus.lsu_addr, bus.lsu_tag, bus.lsu_data};
   assign src_ent[2]   = {bus.mul_addr, bus.mul_tag, bus.mul_data};

   assign bus.alu_ready = src_ready[0];
   assign bus.lsu_ready = src_ready[1];
   assign bus.mul_ready = src_ready[2];

   genvar gi;
   generate
      for (gi = 0; gi < 3; gi++) begin : g_src
         logic [EW-1:0] mem_reg [FIFO_DEPTH];
         logic [PW-1:0] wr_ptr_reg;
         logic [PW-1:0] rd_ptr_reg;
         logic [PW:0]   count_reg;
         logic          push;
         logic          pop;
         logic          granted;

         assign src_ready[gi] = (count_reg != FULL_COUNT) && !bus.flush;
         assign not_empty[gi] = (count_reg != '0);
         // Writes to x0 complete the handshake but never reach the FIFO.
         assign xfer[gi]      = src_valid[gi] && src_ready[gi] && (src_ent[gi][EW-1 -: 5] != 5'd0);
`ifdef WB_BYPASS_EN
         assign cand[gi]      = not_empty[gi] || xfer[gi];
         assign cand_ent[gi]  = not_empty[gi] ? mem_reg[rd_ptr_reg] : src_ent[gi];
`else
         assign cand[gi]      = not_empty[gi];
         assign cand_ent[gi]  = mem_reg[rd_ptr_reg];
`endif
         assign granted = grant_valid && (grant_idx == 2'(gi));
         assign pop     = granted && not_empty[gi];
         // A bypass winner went straight to the output register, so it is not queued.
         assign push    = xfer[gi] && !(granted && !not_empty[gi]);

         always_ff @(posedge clk) begin
            if (push) begin
               mem_reg[wr_ptr_reg] <= src_ent[gi];
            end
         end

         always_ff @(posedge clk) begin
            if (reset || bus.flush) begin
               wr_ptr_reg <= '0;
               rd_ptr_reg <= '0;
               count_reg  <= '0;
            end else begin
               if (push) wr_ptr_reg <= wr_ptr_reg + PW'(1);
               if (pop)  rd_ptr_reg <= rd_ptr_reg + PW'(1);
               case ({push, pop})
                  2'b10:   count_reg <= count_reg + (PW + 1)'(1);
                  2'b01:   count_reg <= count_reg - (PW + 1)'(1);
                  default: count_reg <= count_reg;
               endcase
            end
         end
      end
   endgenerate

   function automatic logic [1:0] wrap3(input logic [1:0] base, input logic [1:0] step);
      logic [2:0] sum;
      sum = {1'b0, base} + {1'b0, step};
      return (sum >= 3'd3) ? 2'(sum - 3'd3) : sum[1:0];
   endfunction

   // Walk the search order backwards so the earliest candidate from rr_ptr wins.
   always_comb begin
      grant_valid = 1'b0;
      grant_idx   = 2'd0;
      for (int k = 2; k >= 0; k--) begin
         if (cand[wrap3(rr_ptr_reg, 2'(k))]) begin
            grant_valid = 1'b1;
            grant_idx   = wrap3(rr_ptr_reg, 2'(k));
         end
      end
   end

   assign grant_ent = cand_ent[grant_idx];

   always_ff @(posedge clk) begin
      if (reset) begin
         rr_ptr_reg <= 2'd0;
         en_reg     <= 1'b0;
         addr_reg   <= '0;
         tag_reg    <= '0;
         data_reg   <= '0;
      end else if (bus.flush) begin
         en_reg <= 1'b0;
      end else begin
         en_reg <= grant_valid;
         if (grant_valid) begin
            {addr_reg, tag_reg, data_reg} <= grant_ent;
            rr_ptr_reg <= (grant_idx == 2'd2) ? 2'd0 : grant_idx + 2'd1;
         end
      end
   end

   assign bus.wr_ch0_en   = en_reg;
   assign bus.wr_ch0_addr = addr_reg;
   assign bus.wr_ch0_tag  = tag_reg;
   assign bus.wr_ch0_data = data_reg;
   assign bus.wb_busy     = (|not_empty) || en_reg;
endmodule
